// File: rtl/cmd_apb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cmd_apb_arbiter
// Purpose  : Round-robin arbiter sharing one decoded-command APB bridge port
//            between NREQ requesters in the cmd_clk domain. The granted
//            requester's payload is latched and driven downstream; the
//            completion (read data / success / error) is routed back to the
//            granted requester only, with an error-acknowledge to the bridge.
// Options  : CMD_ARB_TIMEOUT_EN - builds a BUSY watchdog that turns a hung
//            transaction into an error after TIMEOUT cycles.
// Ports    : cmd_clk, areset_n (async, low), cmd_rst (sync, high)
//            req_vld_i/req_dir_i/req_tag_i/req_lun_i/req_adr_i/req_val_i
//              - packed per-requester command inputs
//            req_rdy_o/req_err_o - one-cycle completion pulses, req_val_o data
//            gnt_o - one-hot grant while BUSY
//            cmd_vld_o/dir/tag/lun/adr/val_o - latched downstream command
//            cmd_ack_o - error acknowledge pulse to the bridge
//            cmd_rdy_i/cmd_err_i/cmd_val_i - downstream completion
// Revision : 1.0 - initial release
// ============================================================================
module cmd_apb_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic             cmd_clk,
    input  logic             areset_n,
    input  logic             cmd_rst,
    input  logic [NREQ-1:0]    req_vld_i,
    input  logic [NREQ-1:0]    req_dir_i,
    input  logic [4*NREQ-1:0]  req_tag_i,
    input  logic [4*NREQ-1:0]  req_lun_i,
    input  logic [28*NREQ-1:0] req_adr_i,
    input  logic [16*NREQ-1:0] req_val_i,
    output logic [NREQ-1:0]    req_rdy_o,
    output logic [NREQ-1:0]    req_err_o,
    output logic [15:0]        req_val_o,
    output logic [NREQ-1:0]    gnt_o,
    output logic               cmd_vld_o,
    output logic               cmd_dir_o,
    output logic [3:0]         cmd_tag_o,
    output logic [3:0]         cmd_lun_o,
    output logic [27:0]        cmd_adr_o,
    output logic [15:0]        cmd_val_o,
    output logic               cmd_ack_o,
    input  logic               cmd_rdy_i,
    input  logic               cmd_err_i,
    input  logic [15:0]        cmd_val_i
);

    localparam int         c_ptr_w   = $clog2(NREQ);
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // Elaboration-time guard on the supported parameter range.
    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_param_chk
        $error("cmd_apb_arbiter: parameter out of range");
    end

    logic [1:0]         r_state, w_state_nxt;
    logic [c_ptr_w-1:0] r_ptr, w_sel;
    logic               w_any, w_ok, w_err, w_tmo;

    logic [NREQ-1:0] r_gnt, r_rdy, r_err;
    logic [15:0]     r_rval;
    logic            r_vld, r_dir, r_ack;
    logic [3:0]      r_tag, r_lun;
    logic [27:0]     r_adr;
    logic [15:0]     r_val;

    // Unpack the flat request buses so the winner can be selected by index.
    logic [3:0]  w_tag [NREQ];
    logic [3:0]  w_lun [NREQ];
    logic [27:0] w_adr [NREQ];
    logic [15:0] w_val [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_tag[gi] = req_tag_i[4*gi +: 4];
        assign w_lun[gi] = req_lun_i[4*gi +: 4];
        assign w_adr[gi] = req_adr_i[28*gi +: 28];
        assign w_val[gi] = req_val_i[16*gi +: 16];
    end

    // Round-robin pick: walk offsets from the far end down to ptr+1 so the
    // nearest set bit after the last grant is the one that sticks.
    always_comb begin
        w_sel = r_ptr;
        w_any = 1'b0;
        for (int off = NREQ; off >= 1; off--) begin
            if (req_vld_i[c_ptr_w'((int'(r_ptr) + off) % NREQ)]) begin
                w_sel = c_ptr_w'((int'(r_ptr) + off) % NREQ);
                w_any = 1'b1;
            end
        end
    end

`ifdef CMD_ARB_TIMEOUT_EN
    localparam logic [15:0] c_tmo_lim = 16'(TIMEOUT - 1);
    logic [15:0] r_wdog;

    always_ff @(posedge cmd_clk or negedge areset_n) begin
        if (!areset_n) begin
            r_wdog <= '0;
        end else if (cmd_rst || r_state != c_st_busy) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 16'd1;
        end
    end

    // A real completion on the same edge outranks the watchdog.
    assign w_tmo = (r_state == c_st_busy) && (r_wdog == c_tmo_lim) && !cmd_rdy_i && !cmd_err_i;
`else
    assign w_tmo = 1'b0;
`endif

    // Error (real or watchdog) beats a simultaneous success.
    assign w_err = cmd_err_i | w_tmo;
    assign w_ok  = cmd_rdy_i & ~w_err;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (w_any) w_state_nxt = c_st_busy;
            c_st_busy: if (w_err || w_ok) w_state_nxt = c_st_done;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge cmd_clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= c_st_idle;
            r_ptr   <= c_ptr_w'(NREQ - 1);
            r_gnt   <= '0;
            r_rdy   <= '0;
            r_err   <= '0;
            r_rval  <= '0;
            r_vld   <= 1'b0;
            r_dir   <= 1'b0;
            r_ack   <= 1'b0;
            r_tag   <= '0;
            r_lun   <= '0;
            r_adr   <= '0;
            r_val   <= '0;
        end else if (cmd_rst) begin
            r_state <= c_st_idle;
            r_ptr   <= c_ptr_w'(NREQ - 1);
            r_gnt   <= '0;
            r_rdy   <= '0;
            r_err   <= '0;
            r_rval  <= '0;
            r_vld   <= 1'b0;
            r_dir   <= 1'b0;
            r_ack   <= 1'b0;
            r_tag   <= '0;
            r_lun   <= '0;
            r_adr   <= '0;
            r_val   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rdy   <= '0;
            r_err   <= '0;
            r_ack   <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_any) begin
                        r_gnt <= NREQ'(1) << w_sel;
                        r_vld <= 1'b1;
                        r_ptr <= w_sel;
                        r_dir <= req_dir_i[w_sel];
                        r_tag <= w_tag[w_sel];
                        r_lun <= w_lun[w_sel];
                        r_adr <= w_adr[w_sel];
                        r_val <= w_val[w_sel];
                    end
                end
                c_st_busy: begin
                    if (w_err) begin
                        r_err <= r_gnt;
                        r_ack <= 1'b1;
                        r_vld <= 1'b0;
                        r_gnt <= '0;
                    end else if (w_ok) begin
                        r_rdy  <= r_gnt;
                        r_rval <= cmd_val_i;
                        r_vld  <= 1'b0;
                        r_gnt  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_rdy_o = r_rdy;
    assign req_err_o = r_err;
    assign req_val_o = r_rval;
    assign gnt_o     = r_gnt;
    assign cmd_vld_o = r_vld;
    assign cmd_dir_o = r_dir;
    assign cmd_tag_o = r_tag;
    assign cmd_lun_o = r_lun;
    assign cmd_adr_o = r_adr;
    assign cmd_val_o = r_val;
    assign cmd_ack_o = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_cmd_apb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmd_apb_arbiter
// Purpose  : Directed self-checking bench for cmd_apb_arbiter (NREQ=4,
//            TIMEOUT=8). Stimulus is driven 1 time unit after each rising
//            edge and outputs are sampled at the same point.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_apb_arbiter;

    logic         cmd_clk = 1'b0;
    logic         areset_n, cmd_rst;
    logic [3:0]   req_vld, req_dir;
    logic [15:0]  req_tag, req_lun;
    logic [111:0] req_adr;
    logic [63:0]  req_val;
    logic [3:0]   req_rdy_o, req_err_o, gnt_o;
    logic [15:0]  req_val_o;
    logic         cmd_vld_o, cmd_dir_o, cmd_ack_o;
    logic [3:0]   cmd_tag_o, cmd_lun_o;
    logic [27:0]  cmd_adr_o;
    logic [15:0]  cmd_val_o;
    logic         cmd_rdy_i, cmd_err_i;
    logic [15:0]  cmd_val_i;

    int checks = 0;
    int failures = 0;

    cmd_apb_arbiter #(.NREQ(4), .TIMEOUT(8)) dut (
        .cmd_clk(cmd_clk), .areset_n(areset_n), .cmd_rst(cmd_rst),
        .req_vld_i(req_vld), .req_dir_i(req_dir), .req_tag_i(req_tag),
        .req_lun_i(req_lun), .req_adr_i(req_adr), .req_val_i(req_val),
        .req_rdy_o(req_rdy_o), .req_err_o(req_err_o), .req_val_o(req_val_o),
        .gnt_o(gnt_o), .cmd_vld_o(cmd_vld_o), .cmd_dir_o(cmd_dir_o),
        .cmd_tag_o(cmd_tag_o), .cmd_lun_o(cmd_lun_o), .cmd_adr_o(cmd_adr_o),
        .cmd_val_o(cmd_val_o), .cmd_ack_o(cmd_ack_o), .cmd_rdy_i(cmd_rdy_i),
        .cmd_err_i(cmd_err_i), .cmd_val_i(cmd_val_i)
    );

    always #5 cmd_clk = ~cmd_clk;

    task automatic step();
        @(posedge cmd_clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic dir, input logic [3:0] tag,
                           input logic [27:0] adr, input logic [15:0] val);
        req_dir[i]        = dir;
        req_tag[4*i +: 4] = tag;
        req_lun[4*i +: 4] = tag ^ 4'hF;
        req_adr[28*i +: 28] = adr;
        req_val[16*i +: 16] = val;
    endtask

    task automatic do_reset();
        areset_n = 1'b0; cmd_rst = 1'b0;
        req_vld = '0; req_dir = '0; req_tag = '0; req_lun = '0;
        req_adr = '0; req_val = '0;
        cmd_rdy_i = 1'b0; cmd_err_i = 1'b0; cmd_val_i = '0;
        step();
        areset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({gnt_o, req_rdy_o, req_err_o} !== 12'h0) begin failures++; $display("FAIL reset_pulses: got %h want 000", {gnt_o, req_rdy_o, req_err_o}); end
        checks++; if ({cmd_vld_o, cmd_ack_o, cmd_dir_o} !== 3'b000) begin failures++; $display("FAIL reset_ctl: got %b want 000", {cmd_vld_o, cmd_ack_o, cmd_dir_o}); end
        checks++; if ({cmd_tag_o, cmd_lun_o, cmd_adr_o, cmd_val_o, req_val_o} !== 68'h0) begin failures++; $display("FAIL reset_data: got %h want 0", {cmd_tag_o, cmd_lun_o, cmd_adr_o, cmd_val_o, req_val_o}); end
    endtask

    task automatic test_single_read();
        do_reset();
        set_req(2, 1'b1, 4'h5, 28'h0000123, 16'h0);
        req_vld = 4'b0100;
        step();
        checks++; if (gnt_o !== 4'b0100 || cmd_vld_o !== 1'b1) begin failures++; $display("FAIL rd_grant: gnt=%b vld=%b want 0100/1", gnt_o, cmd_vld_o); end
        checks++; if ({cmd_dir_o, cmd_tag_o, cmd_lun_o, cmd_adr_o} !== {1'b1, 4'h5, 4'hA, 28'h0000123}) begin failures++; $display("FAIL rd_payload: got %h want %h", {cmd_dir_o, cmd_tag_o, cmd_lun_o, cmd_adr_o}, {1'b1, 4'h5, 4'hA, 28'h0000123}); end
        // Payload may change after the grant; the latched copy must hold.
        set_req(2, 1'b0, 4'h9, 28'h0FFFFFF, 16'h0);
        for (int c = 0; c < 4; c++) begin
            step();
            checks++; if (cmd_vld_o !== 1'b1 || req_rdy_o !== 4'h0 || cmd_adr_o !== 28'h0000123) begin failures++; $display("FAIL rd_busy: vld=%b rdy=%b adr=%h want 1/0000/0000123", cmd_vld_o, req_rdy_o, cmd_adr_o); end
        end
        cmd_rdy_i = 1'b1; cmd_val_i = 16'hBEEF;
        step();
        cmd_rdy_i = 1'b0; cmd_val_i = 16'h0;
        checks++; if (req_rdy_o !== 4'b0100 || req_val_o !== 16'hBEEF) begin failures++; $display("FAIL rd_done: rdy=%b val=%h want 0100/beef", req_rdy_o, req_val_o); end
        checks++; if ({cmd_vld_o, gnt_o, req_err_o, cmd_ack_o} !== 10'h0) begin failures++; $display("FAIL rd_done_ctl: got %h want 000", {cmd_vld_o, gnt_o, req_err_o, cmd_ack_o}); end
        req_vld = 4'b0000;
        step();
        checks++; if (req_rdy_o !== 4'h0 || cmd_vld_o !== 1'b0) begin failures++; $display("FAIL rd_pulse_len: rdy=%b vld=%b want 0000/0", req_rdy_o, cmd_vld_o); end
    endtask

    task automatic test_round_robin();
        int order [4] = '{0, 1, 3, 0};
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 4'(i), 28'(i * 16), 16'h0);
        req_vld = 4'b1011;
        for (int t = 0; t < 4; t++) begin
            step();
            checks++; if (gnt_o !== (4'b0001 << order[t]) || cmd_vld_o !== 1'b1 || cmd_tag_o !== 4'(order[t])) begin failures++; $display("FAIL rr_grant%0d: gnt=%b tag=%h want %b/%h", t, gnt_o, cmd_tag_o, 4'b0001 << order[t], order[t]); end
            cmd_rdy_i = 1'b1; cmd_val_i = 16'(16'h1000 + t);
            step();
            cmd_rdy_i = 1'b0;
            checks++; if (req_rdy_o !== (4'b0001 << order[t]) || cmd_vld_o !== 1'b0 || req_val_o !== 16'(16'h1000 + t)) begin failures++; $display("FAIL rr_done%0d: rdy=%b vld=%b val=%h", t, req_rdy_o, cmd_vld_o, req_val_o); end
            step();
            checks++; if (cmd_vld_o !== 1'b0 || gnt_o !== 4'h0 || req_rdy_o !== 4'h0) begin failures++; $display("FAIL rr_idle%0d: vld=%b gnt=%b rdy=%b want 0/0000/0000", t, cmd_vld_o, gnt_o, req_rdy_o); end
        end
        req_vld = 4'b0000;
    endtask

    task automatic test_error();
        do_reset();
        set_req(1, 1'b0, 4'h3, 28'h0ABCDEF, 16'h5A5A);
        req_vld = 4'b0010;
        step();
        checks++; if (gnt_o !== 4'b0010 || cmd_dir_o !== 1'b0 || cmd_val_o !== 16'h5A5A) begin failures++; $display("FAIL err_grant: gnt=%b dir=%b val=%h want 0010/0/5a5a", gnt_o, cmd_dir_o, cmd_val_o); end
        step();
        cmd_err_i = 1'b1;
        step();
        cmd_err_i = 1'b0;
        checks++; if (req_err_o !== 4'b0010 || cmd_ack_o !== 1'b1 || req_rdy_o !== 4'h0 || cmd_vld_o !== 1'b0) begin failures++; $display("FAIL err_done: err=%b ack=%b rdy=%b vld=%b want 0010/1/0000/0", req_err_o, cmd_ack_o, req_rdy_o, cmd_vld_o); end
        req_vld = 4'b0000;
        step();
        checks++; if (req_err_o !== 4'h0 || cmd_ack_o !== 1'b0) begin failures++; $display("FAIL err_pulse_len: err=%b ack=%b want 0000/0", req_err_o, cmd_ack_o); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_req(0, 1'b1, 4'h1, 28'h10, 16'h0);
        set_req(1, 1'b1, 4'h2, 28'h20, 16'h0);
        req_vld = 4'b0001;
        step();
        cmd_rdy_i = 1'b1; cmd_val_i = 16'h1234;
        step();
        cmd_rdy_i = 1'b0;
        checks++; if (req_val_o !== 16'h1234 || req_rdy_o !== 4'b0001) begin failures++; $display("FAIL sim_first: val=%h rdy=%b want 1234/0001", req_val_o, req_rdy_o); end
        req_vld = 4'b0010;
        step();
        step();
        checks++; if (gnt_o !== 4'b0010) begin failures++; $display("FAIL sim_grant: gnt=%b want 0010", gnt_o); end
        cmd_rdy_i = 1'b1; cmd_err_i = 1'b1; cmd_val_i = 16'hFFFF;
        step();
        cmd_rdy_i = 1'b0; cmd_err_i = 1'b0;
        checks++; if (req_err_o !== 4'b0010 || req_rdy_o !== 4'h0 || cmd_ack_o !== 1'b1 || req_val_o !== 16'h1234) begin failures++; $display("FAIL sim_both: err=%b rdy=%b ack=%b val=%h want 0010/0000/1/1234", req_err_o, req_rdy_o, cmd_ack_o, req_val_o); end
        req_vld = 4'b0000;
        step();
    endtask

    task automatic test_cmd_rst();
        do_reset();
        set_req(1, 1'b1, 4'h7, 28'h0000777, 16'h0);
        req_vld = 4'b0010;
        step();
        checks++; if (gnt_o !== 4'b0010) begin failures++; $display("FAIL rst_pre: gnt=%b want 0010", gnt_o); end
        cmd_rst = 1'b1; cmd_rdy_i = 1'b1; cmd_val_i = 16'hCAFE;
        step();
        cmd_rst = 1'b0; cmd_rdy_i = 1'b0;
        checks++; if ({gnt_o, req_rdy_o, req_err_o, cmd_vld_o, cmd_ack_o} !== 14'h0 || cmd_adr_o !== 28'h0 || req_val_o !== 16'h0) begin failures++; $display("FAIL rst_outs: gnt=%b rdy=%b err=%b vld=%b ack=%b adr=%h val=%h want all 0", gnt_o, req_rdy_o, req_err_o, cmd_vld_o, cmd_ack_o, cmd_adr_o, req_val_o); end
        req_vld = 4'b1111;
        step();
        checks++; if (gnt_o !== 4'b0001) begin failures++; $display("FAIL rst_ptr: gnt=%b want 0001", gnt_o); end
    endtask

    task automatic test_timeout();
        int bad = 0;
        do_reset();
        set_req(3, 1'b1, 4'hC, 28'h0000333, 16'h0);
        req_vld = 4'b1000;
        step();
        checks++; if (cmd_vld_o !== 1'b1 || gnt_o !== 4'b1000) begin failures++; $display("FAIL tmo_grant: vld=%b gnt=%b want 1/1000", cmd_vld_o, gnt_o); end
`ifdef CMD_ARB_TIMEOUT_EN
        for (int c = 2; c <= 8; c++) begin
            step();
            if (cmd_vld_o !== 1'b1 || req_err_o !== 4'h0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL tmo_wait: early exit in %0d cycles want 0", bad); end
        step();
        checks++; if (req_err_o !== 4'b1000 || cmd_ack_o !== 1'b1 || cmd_vld_o !== 1'b0) begin failures++; $display("FAIL tmo_fire: err=%b ack=%b vld=%b want 1000/1/0", req_err_o, cmd_ack_o, cmd_vld_o); end
`else
        for (int c = 2; c <= 1000; c++) begin
            step();
            if (cmd_vld_o !== 1'b1 || req_err_o !== 4'h0 || cmd_ack_o !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL tmo_hold: %0d cycles left BUSY want 0", bad); end
`endif
        req_vld = 4'b0000;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_error();
        test_simultaneous();
        test_cmd_rst();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
